multi_push_queue: RTL and testbench

Age-ordered buffer for up to Size entries with PushWidth parallel append lanes, an arbitrary per-entry removal mask, and a whole-queue flush. Entries stay compacted toward index 0 in arrival order, and every slot is exposed in parallel. It serves as the next-generation issue/wakeup buffer for multi-wide dispatch: dispatch appends up to PushWidth entries per cycle, and consumers retire any subset each cycle.

---
 rtl/multi_push_queue.sv | 83 ++++++++
 tb/tb_multi_push_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multi_push_queue.sv
// Age-ordered queue: PushWidth append lanes, arbitrary pop mask, flush; all slots exposed.
// Updates on the falling edge (1 edge latency); pushes all-or-nothing, accepted only while free_o >= PushWidth.
module multi_push_queue #(
  parameter int Size      = 16,
  parameter int PushWidth = 2,
  parameter type T        = logic [31:0]
) (
  input  logic                  clk_ni,
  input  logic                  rst_i,
  input  logic [PushWidth-1:0]  push_valid_i,
  input  T                      push_data_i [PushWidth],
  output logic                  push_ready_o,
  input  logic [Size-1:0]       pop_i,
  input  logic                  flush_i,
  output logic [$clog2(Size):0] size_o,
  output logic [$clog2(Size):0] free_o,
  output logic [Size-1:0]       valid_o,
  output T                      data_o [Size]
);

  localparam int Width = $clog2(Size);

  logic [Width:0] size_q, size_d;
  logic [Width:0] cnt;
  T               data_q [Size];
  T               data_d [Size];

  assign size_o       = size_q;
  assign free_o       = (Width+1)'(Size) - size_q;
  assign push_ready_o = (free_o >= (Width+1)'(PushWidth));
  assign data_o       = data_q;

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < Size; i++) begin
      valid_o[i] = ((Width+1)'(i) < size_q);
    end
  end

  // Survivors compact toward 0, then accepted lanes append densely after them.
  always_comb begin
    data_d = data_q;
    cnt    = '0;
    size_d = size_q;
    if (flush_i) begin
      size_d = '0;
    end else begin
      for (int i = 0; i < Size; i++) begin
        if (((Width+1)'(i) < size_q) && !pop_i[i]) begin
          data_d[cnt[Width-1:0]] = data_q[i];
          cnt = cnt + (Width+1)'(1);
        end
      end
      if (push_ready_o) begin
        for (int k = 0; k < PushWidth; k++) begin
          if (push_valid_i[k]) begin
            if (cnt < (Width+1)'(Size)) begin
              data_d[cnt[Width-1:0]] = push_data_i[k];
            end
            cnt = cnt + (Width+1)'(1);
          end
        end
      end
      size_d = cnt;
    end
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      size_q <= '0;
    end else begin
      size_q <= size_d;
    end
  end

  // Payload storage is never reset; slots beyond size_o are don't-care.
  always_ff @(negedge clk_ni) begin
    for (int i = 0; i < Size; i++) begin
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_multi_push_queue.sv
// Directed bench for multi_push_queue (Size=16, PushWidth=2); checks sampled 1 time unit after each falling edge.
module tb_multi_push_queue;

  logic        clk_ni = 1'b1;
  logic        rst_i;
  logic [1:0]  push_valid_i;
  logic [31:0] push_data_i [2];
  logic        push_ready_o;
  logic [15:0] pop_i;
  logic        flush_i;
  logic [4:0]  size_o;
  logic [4:0]  free_o;
  logic [15:0] valid_o;
  logic [31:0] data_o [16];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003;
  localparam logic [31:0] D = 32'hDDDD_0004, E = 32'hEEEE_0005, F = 32'hFFFF_0006;
  localparam logic [31:0] X = 32'h1234_5678, G = 32'h6666_0007, H = 32'h7777_0008;
  localparam logic [31:0] P = 32'h5050_0009, Q = 32'h5151_000A, R = 32'h5252_000B;

  multi_push_queue #(.Size(16), .PushWidth(2)) dut (
    .clk_ni       (clk_ni),
    .rst_i        (rst_i),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .push_ready_o (push_ready_o),
    .pop_i        (pop_i),
    .flush_i      (flush_i),
    .size_o       (size_o),
    .free_o       (free_o),
    .valid_o      (valid_o),
    .data_o       (data_o)
  );

  always #5 clk_ni = ~clk_ni;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let one falling edge pass, then return inputs to idle.
  task automatic step(input logic [1:0] pv, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [15:0] pop, input logic fl);
    push_valid_i   = pv;
    push_data_i[0] = d0;
    push_data_i[1] = d1;
    pop_i          = pop;
    flush_i        = fl;
    @(negedge clk_ni);
    #1;
    push_valid_i = 2'b00;
    pop_i        = 16'h0000;
    flush_i      = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    push_valid_i   = 2'b00;
    push_data_i[0] = '0;
    push_data_i[1] = '0;
    pop_i          = '0;
    flush_i        = 1'b0;

    // Reset held for two edges with random traffic
    for (int i = 0; i < 2; i++) begin
      push_valid_i   = 2'($urandom_range(3));
      push_data_i[0] = $urandom;
      push_data_i[1] = $urandom;
      pop_i          = 16'($urandom);
      @(negedge clk_ni);
      #1;
    end
    chk("rst_size", 64'(size_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_free", 64'(free_o), 64'd16);
    chk("rst_ready", 64'(push_ready_o), 64'd1);
    rst_i = 1'b0;

    // Dual push
    step(2'b11, A, B, 16'h0, 1'b0);
    chk("push1_size", 64'(size_o), 64'd2);
    step(2'b11, C, D, 16'h0, 1'b0);
    chk("push2_size", 64'(size_o), 64'd4);
    chk("push2_d0", 64'(data_o[0]), 64'(A));
    chk("push2_d1", 64'(data_o[1]), 64'(B));
    chk("push2_d2", 64'(data_o[2]), 64'(C));
    chk("push2_d3", 64'(data_o[3]), 64'(D));
    chk("push2_valid", 64'(valid_o), 64'h000F);

    // Lane gap: only lane 1
    step(2'b10, 32'hDEAD_BEEF, X, 16'h0, 1'b0);
    chk("gap_d4", 64'(data_o[4]), 64'(X));
    chk("gap_size", 64'(size_o), 64'd5);

    // Drop the tail to return to A,B,C,D
    step(2'b00, 32'h0, 32'h0, 16'h0010, 1'b0);
    chk("trim_size", 64'(size_o), 64'd4);
    chk("trim_d3", 64'(data_o[3]), 64'(D));

    // Pop 0 and 2 (bit 15 beyond size) while pushing E,F
    step(2'b11, E, F, 16'h8005, 1'b0);
    chk("pp_d0", 64'(data_o[0]), 64'(B));
    chk("pp_d1", 64'(data_o[1]), 64'(D));
    chk("pp_d2", 64'(data_o[2]), 64'(E));
    chk("pp_d3", 64'(data_o[3]), 64'(F));
    chk("pp_size", 64'(size_o), 64'd4);
    chk("pp_valid", 64'(valid_o), 64'h000F);

    // Fill to 15: five dual pushes then one single push (fill values 0x100..0x10A)
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 16'h0, 1'b0);
    end
    step(2'b01, 32'h10A, 32'h0, 16'h0, 1'b0);
    chk("fill_size", 64'(size_o), 64'd15);
    chk("fill_free", 64'(free_o), 64'd1);
    chk("fill_ready", 64'(push_ready_o), 64'd0);
    chk("fill_d14", 64'(data_o[14]), 64'h10A);

    // Push while not ready is dropped entirely
    step(2'b11, G, H, 16'h0, 1'b0);
    chk("bp_size", 64'(size_o), 64'd15);
    chk("bp_d14", 64'(data_o[14]), 64'h10A);

    // Pop entry 0 reopens the queue
    step(2'b00, 32'h0, 32'h0, 16'h0001, 1'b0);
    chk("bp_pop_size", 64'(size_o), 64'd14);
    chk("bp_pop_ready", 64'(push_ready_o), 64'd1);
    chk("bp_pop_d0", 64'(data_o[0]), 64'(D));
    chk("bp_pop_d13", 64'(data_o[13]), 64'h10A);

    step(2'b11, G, H, 16'h0, 1'b0);
    chk("full_size", 64'(size_o), 64'd16);
    chk("full_d14", 64'(data_o[14]), 64'(G));
    chk("full_d15", 64'(data_o[15]), 64'(H));
    chk("full_free", 64'(free_o), 64'd0);
    chk("full_ready", 64'(push_ready_o), 64'd0);
    chk("full_valid", 64'(valid_o), 64'hFFFF);

    // Pop last entry while full
    step(2'b00, 32'h0, 32'h0, 16'h8000, 1'b0);
    chk("fullpop_size", 64'(size_o), 64'd15);
    chk("fullpop_d14", 64'(data_o[14]), 64'(G));

    // Flush beats push and pop
    step(2'b11, P, Q, 16'hFFFF, 1'b1);
    chk("flush_size", 64'(size_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'h0);
    chk("flush_ready", 64'(push_ready_o), 64'd1);

    step(2'b01, R, 32'h0, 16'h0, 1'b0);
    chk("post_flush_d0", 64'(data_o[0]), 64'(R));
    chk("post_flush_size", 64'(size_o), 64'd1);

    // Pop everything while pushing: lanes land at index 0
    step(2'b11, A, B, 16'hFFFF, 1'b0);
    chk("popall_size", 64'(size_o), 64'd2);
    chk("popall_d0", 64'(data_o[0]), 64'(A));
    chk("popall_d1", 64'(data_o[1]), 64'(B));

    // Reset mid-stream
    rst_i = 1'b1;
    step(2'b11, C, D, 16'h0, 1'b0);
    rst_i = 1'b0;
    chk("midrst_size", 64'(size_o), 64'd0);
    step(2'b01, E, 32'h0, 16'h0, 1'b0);
    chk("midrst_d0", 64'(data_o[0]), 64'(E));
    chk("midrst_size1", 64'(size_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
